// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE chain sequencer.
package pe_ctrl_pkg;

    localparam int LANE_W = 32;
    localparam logic [LANE_W-1:0] FP_ZERO = 32'h00000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/pe_chain_controller.sv
// Runs one job on a linear PE chain: clear, stream K operand beats, then
// shift the N_PE accumulated results out of the chain tail.
module pe_chain_controller
    import pe_ctrl_pkg::*;
#(
    parameter int N_PE  = 4,
    parameter int LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         vec_len,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANE_W*N_PE-1:0]   in_data,
    input  logic [LANE_W*N_PE-1:0]   in_weight,
    output logic                     pe_reset,
    output logic                     pe_mode,
    output logic [LANE_W*N_PE-1:0]   pe_data,
    output logic [LANE_W*N_PE-1:0]   pe_weight,
    input  logic [LANE_W-1:0]        chain_tail,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W-1:0]        out_data,
    output logic                     out_last
);

    localparam int CNT_W = $clog2(N_PE) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N_PE - 1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] beat_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic             accept;
    logic             drain_hs;

    assign beat_nxt = beat_cnt + 1'b1;
    assign accept   = (state == ST_ACCUM) && in_valid;
    assign drain_hs = (state == ST_DRAIN) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            pe_reset  <= 1'b1;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            pe_reset <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len       <= vec_len;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                        pe_reset  <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state <= (len != '0) ? ST_ACCUM : ST_DRAIN;
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        beat_cnt <= beat_nxt;
                        if (beat_nxt == len) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Idle operand slots feed +0 x +0 so a stray Inf on the bus cannot make NaN.
    always_comb begin
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_ACCUM);
        out_valid = (state == ST_DRAIN);
        out_data  = out_valid ? chain_tail : FP_ZERO;
        out_last  = out_valid && (drain_cnt == DRAIN_LAST);
        pe_mode   = drain_hs;
        pe_data   = accept ? in_data   : {N_PE{FP_ZERO}};
        pe_weight = accept ? in_weight : {N_PE{FP_ZERO}};
    end

endmodule

// File: tb/tb_pe_chain_controller.sv
// Directed bench: a behavioural float MAC chain sits behind the controller.
module tb_pe_chain_controller;

    localparam int N   = 4;
    localparam int LW  = 16;
    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F10 = 32'h41200000;
    localparam logic [31:0] INF = 32'h7F800000;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   vec_len;
    logic            busy, done;
    logic            in_valid, in_ready;
    logic [32*N-1:0] in_data, in_weight;
    logic            pe_reset, pe_mode;
    logic [32*N-1:0] pe_data, pe_weight;
    logic [31:0]     chain_tail;
    logic            out_valid, out_ready, out_last;
    logic [31:0]     out_data;

    int n_chk  = 0;
    int n_pass = 0;

    pe_chain_controller #(.N_PE(N), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .pe_reset(pe_reset),
        .pe_mode(pe_mode), .pe_data(pe_data), .pe_weight(pe_weight),
        .chain_tail(chain_tail), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00) return 0.0;
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'h0) return $bitstoreal(64'h7FF8000000000000);
            return $bitstoreal({f[31], 11'h7FF, 52'h0});
        end
        e = 11'(int'(f[30:23]) - 127 + 1023);
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [7:0]  e;
        b = $realtobits(r);
        if (b[62:52] == 11'h000) return {b[63], 31'h0};
        if (b[62:52] == 11'h7FF) return (b[51:0] != 52'h0) ? 32'h7FC00000 : {b[63], 8'hFF, 23'h0};
        e = 8'(int'(b[62:52]) - 1023 + 127);
        return {b[63], e, b[51:29]};
    endfunction

    // Reference PE chain: clear, MAC, or load from the upstream neighbour.
    logic [31:0] acc [N];
    assign chain_tail = acc[N-1];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pe_reset)     acc[i] <= 32'h0;
            else if (pe_mode) acc[i] <= (i == 0) ? 32'h0 : acc[i-1];
            else acc[i] <= r2f(f2r(acc[i]) + f2r(pe_data[i*32 +: 32]) * f2r(pe_weight[i*32 +: 32]));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [31:0] got_d [$];
    bit          got_l [$];
    int          lat, first_ov;

    // Runs one job; toggle pulses in_valid on alternate cycles with Inf weights
    // in the gaps, stall_at holds out_ready low 3 cycles after that many beats.
    task automatic run_job(input int k, input logic [32*N-1:0] d, input logic [32*N-1:0] w,
                           input bit toggle, input int stall_at);
        int c, stall_n;
        bit fin;
        got_d.delete(); got_l.delete();
        lat = -1; first_ov = -1; stall_n = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; vec_len = LW'(k);
        @(negedge clk);
        start = 1'b0;
        for (c = 1; c < 100 && !fin; c++) begin
            in_valid  = toggle ? c[0] : 1'b1;
            in_data   = d;
            in_weight = (toggle && !in_valid) ? {N{INF}} : w;
            if (out_valid && stall_at >= 0 && got_d.size() == stall_at && stall_n < 3) begin
                out_ready = 1'b0;
                stall_n++;
            end else out_ready = 1'b1;
            #1;
            if (out_valid && first_ov < 0) first_ov = c;
            if (out_valid && !out_ready) chk("stall_mode", {31'h0, pe_mode}, 32'h0);
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            if (done) begin
                lat = c;
                fin = 1;
            end else @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        if (!fin) chk("job_timeout", 32'h0, 32'h1);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] e3, input logic [31:0] e2,
                           input logic [31:0] e1, input logic [31:0] e0);
        logic [31:0] exp [4];
        exp = '{e3, e2, e1, e0};
        chk({tag, "_nbeats"}, got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), got_d[i], exp[i]);
            chk($sformatf("%s_l%0d", tag, i), {31'h0, got_l[i]}, (i == 3) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        int w;
        reset = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_weight = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_last", {31'h0, out_last}, 32'h0);
        chk("rst_pe_mode", {31'h0, pe_mode}, 32'h0);
        chk("rst_pe_data", {31'h0, pe_data == '0 && pe_weight == '0}, 32'h1);
        chk("rst_out_data", out_data, 32'h0);
        reset = 1'b0;

        // Basic job: 2 x (1.0 * 2.0) per lane.
        run_job(2, {N{F1}}, {N{F2}}, 0, -1);
        chk_res("basic", F4, F4, F4, F4);
        chk("basic_latency", lat, 8);
        chk("basic_busy_at_done", {31'h0, busy}, 32'h0);

        // Lane order: tail (PE3) first.
        run_job(1, {F4, F3, F2, F1}, {N{F1}}, 0, -1);
        chk_res("order", F4, F3, F2, F1);

        // Backpressure: 3 beats of lane i = i+1, weight 1 -> 3,6,9,12.
        run_job(3, {F4, F3, F2, F1}, {N{F1}}, 1, 2);
        chk_res("bp", 32'h41400000, 32'h41100000, 32'h40C00000, F3);

        // K = 0: zeros, out_valid in cycle 2.
        run_job(0, {N{F10}}, {N{F10}}, 0, -1);
        chk_res("k0", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("k0_first_valid", first_ov, 2);
        chk("k0_latency", lat, 6);

        // Back-to-back, start the cycle after done.
        run_job(2, {N{F2}}, {N{F2}}, 0, -1);
        run_job(1, {N{F3}}, {N{F1}}, 0, -1);
        chk_res("b2b", F3, F3, F3, F3);

        // Reset during ACCUM.
        @(negedge clk);
        start = 1'b1; vec_len = LW'(5);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = {N{F4}}; in_weight = {N{F4}};
        @(negedge clk);
        chk("pre_rst_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rstA_busy", {31'h0, busy}, 32'h0);
        chk("rstA_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("rstA_out_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b0; in_valid = 1'b0;

        // Reset during DRAIN after one beat left.
        @(negedge clk);
        start = 1'b1; vec_len = LW'(1);
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!out_valid && w < 20) begin @(negedge clk); w++; end
        chk("rstB_reached_drain", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rstB_busy", {31'h0, busy}, 32'h0);
        chk("rstB_pe_reset", {31'h0, pe_reset}, 32'h1);
        chk("rstB_out_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        run_job(1, {N{F10}}, {N{F1}}, 0, -1);
        chk_res("post_rst", F10, F10, F10, F10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
